// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues word reads and
// buffers responses in an in-order prefetch queue feeding decode.
module instr_fetch_unit #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned IMEM_BYTES = 256,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;

    logic [31:0]      fetch_pc;
    logic [31:0]      slot_pc   [DEPTH];
    logic [31:0]      slot_data [DEPTH];
    logic [DEPTH-1:0] slot_full;
    logic [AW-1:0]    alloc_ptr;
    logic [AW-1:0]    fill_ptr;
    logic [AW-1:0]    read_ptr;
    logic [AW:0]      count;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    drop_cnt;

    logic        pop;
    logic [AW:0] occ_after_pop;
    logic        has_room;
    logic        in_range;
    logic        issue;
    logic        oor_fill;
    logic        alloc;
    logic        resp_drop;
    logic        resp_take;
    logic        resp_stray;
    logic        unused_tgt;

    assign unused_tgt = ^branch_target[1:0];

    assign inst_valid = slot_full[read_ptr];
    assign inst_data  = slot_data[read_ptr];
    assign inst_pc    = slot_pc[read_ptr];

    assign pop           = inst_valid & inst_ready;
    assign occ_after_pop = count - (AW+1)'(pop);
    assign has_room      = occ_after_pop < (AW+1)'(DEPTH);
    assign in_range      = fetch_pc < 32'(IMEM_BYTES);

    assign req_valid = !reset && !branch_valid && has_room && in_range;
    assign req_addr  = fetch_pc;
    assign issue     = req_valid & req_ready;

    // Nop fill waits for outstanding==0 so it cannot overtake real reads
    assign oor_fill = !reset && !branch_valid && has_room
                    && !in_range && (outstanding == '0);
    assign alloc    = issue | oor_fill;

    assign resp_drop  = resp_valid && (drop_cnt != '0);
    assign resp_take  = resp_valid && (drop_cnt == '0)
                      && (outstanding != '0);
    assign resp_stray = resp_valid && (drop_cnt == '0)
                      && (outstanding == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            read_ptr    <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            slot_full   <= '0;
            proto_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_pc[i]   <= '0;
                slot_data[i] <= '0;
            end
        end else if (branch_valid) begin
            fetch_pc    <= {branch_target[31:2], 2'b00};
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            read_ptr    <= '0;
            count       <= '0;
            slot_full   <= '0;
            outstanding <= '0;
            // A same-cycle response retires one stale read either way
            drop_cnt <= drop_cnt + outstanding
                      - CW'(resp_drop | resp_take);
            if (resp_stray) begin
                proto_err <= 1'b1;
            end
        end else begin
            if (pop) begin
                slot_full[read_ptr] <= 1'b0;
                read_ptr            <= read_ptr + 1'b1;
            end
            if (resp_drop) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
            if (resp_take) begin
                slot_data[fill_ptr] <= resp_data;
                slot_full[fill_ptr] <= 1'b1;
                fill_ptr            <= fill_ptr + 1'b1;
            end
            if (resp_stray) begin
                proto_err <= 1'b1;
            end
            if (alloc) begin
                slot_pc[alloc_ptr]   <= fetch_pc;
                slot_full[alloc_ptr] <= oor_fill;
                alloc_ptr            <= alloc_ptr + 1'b1;
                fetch_pc             <= fetch_pc + 32'd4;
            end
            if (oor_fill) begin
                slot_data[alloc_ptr] <= 32'h0;
                fill_ptr             <= fill_ptr + 1'b1;
            end
            outstanding <= outstanding + CW'(issue) - CW'(resp_take);
            count       <= count + (AW+1)'(alloc) - (AW+1)'(pop);
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: latency-configurable memory responder
// and a scoreboard of expected (pc, data) deliveries.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        proto_err;

    instr_fetch_unit #(
        .DEPTH(4),
        .IMEM_BYTES(256),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .resp_valid(resp_valid),
        .resp_data(resp_data),
        .branch_valid(branch_valid),
        .branch_target(branch_target),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_data(inst_data),
        .inst_pc(inst_pc),
        .proto_err(proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic [31:0] mem [64];
    mreq_t       mq [$];
    exp_t        sb [$];
    int          lat = 1;
    int          cyc = 0;
    logic        inject = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd256) return mem[a[7:2]];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        if (pc < 32'd256) return mem[pc[7:2]];
        return 32'h0;
    endfunction

    task automatic push_stream(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] p;
            p = start + 32'(4 * i);
            sb.push_back('{p, exp_word(p)});
        end
    endtask

    // In-order memory responder; responses for a handshake in cycle k
    // appear no earlier than cycle k+lat
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        resp_valid <= 1'b0;
        resp_data  <= 32'h0;
        if (reset) begin
            mq.delete();
        end else begin
            if (req_valid && req_ready) mq.push_back('{req_addr, cyc + lat});
            if (inject) begin
                resp_valid <= 1'b1;
                resp_data  <= 32'h1234_5678;
            end else if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
                resp_valid <= 1'b1;
                resp_data  <= mem_word(mq[0].addr);
                void'(mq.pop_front());
            end
        end
    end

    task automatic start_run(input int l, input logic rdy);
        @(negedge clk);
        reset         = 1'b1;
        lat           = l;
        inst_ready    = rdy;
        req_ready     = 1'b1;
        branch_valid  = 1'b0;
        branch_target = 32'h0;
        inject        = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_stream;
        int   first;
        int   last;
        int   popped;
        exp_t e;
        @(negedge clk);
        reset = 1'b1; lat = 1; req_ready = 1'b1; inst_ready = 1'b1;
        branch_valid = 1'b0; branch_target = 32'h0; inject = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (req_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_req_valid got %b want 0", req_valid);
        end
        n_cmp++;
        if (req_addr !== 32'h0) begin
            n_bad++; $display("FAIL rst_req_addr got %h want 0", req_addr);
        end
        n_cmp++;
        if (inst_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_inst_valid got %b want 0", inst_valid);
        end
        n_cmp++;
        if (inst_data !== 32'h0) begin
            n_bad++; $display("FAIL rst_inst_data got %h want 0", inst_data);
        end
        n_cmp++;
        if (inst_pc !== 32'h0) begin
            n_bad++; $display("FAIL rst_inst_pc got %h want 0", inst_pc);
        end
        n_cmp++;
        if (proto_err !== 1'b0) begin
            n_bad++; $display("FAIL rst_proto_err got %b want 0", proto_err);
        end
        sb.delete();
        push_stream(32'h0, 3);
        @(negedge clk);
        reset  = 1'b0;
        first  = -1;
        last   = -1;
        popped = 0;
        for (int k = 0; k < 12 && popped < 3; k++) begin
            #1;
            if (inst_valid) begin
                if (first < 0) first = k;
                last = k;
                e = sb.pop_front();
                n_cmp++;
                if ({inst_pc, inst_data} !== {e.pc, e.data}) begin
                    n_bad++;
                    $display("FAIL t1_pop got %h/%h want %h/%h",
                             inst_pc, inst_data, e.pc, e.data);
                end
                popped++;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (first !== 2 || last !== 4) begin
            n_bad++;
            $display("FAIL t1_timing got first=%0d last=%0d want 2/4",
                     first, last);
        end
    endtask

    task automatic test_backpressure;
        int   hs;
        int   popped;
        exp_t e;
        start_run(1, 1'b0);
        push_stream(32'h0, 6);
        hs = 0;
        repeat (12) begin
            #1;
            if (req_valid && req_ready) begin
                n_cmp++;
                if (req_addr !== 32'(hs * 4)) begin
                    n_bad++;
                    $display("FAIL t2_req_addr got %h want %h",
                             req_addr, 32'(hs * 4));
                end
                hs++;
            end
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (hs !== 4 || req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL t2_full got hs=%0d req_valid=%b want 4/0",
                     hs, req_valid);
        end
        @(negedge clk);
        inst_ready = 1'b1;
        #1;
        n_cmp++;
        if ({req_valid, req_addr} !== {1'b1, 32'h10}) begin
            n_bad++;
            $display("FAIL t2_resume got %b/%h want 1/00000010",
                     req_valid, req_addr);
        end
        popped = 0;
        repeat (16) begin
            if (inst_valid && popped < 6) begin
                e = sb.pop_front();
                n_cmp++;
                if ({inst_pc, inst_data} !== {e.pc, e.data}) begin
                    n_bad++;
                    $display("FAIL t2_pop got %h/%h want %h/%h",
                             inst_pc, inst_data, e.pc, e.data);
                end
                popped++;
            end
            @(negedge clk);
            #1;
        end
        n_cmp++;
        if (popped !== 6) begin
            n_bad++; $display("FAIL t2_count got %0d want 6", popped);
        end
    endtask

    task automatic test_branch_inflight;
        int   popped;
        logic seen;
        exp_t e;
        start_run(3, 1'b1);
        push_stream(32'h0, 8);
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            #1;
            if (inst_valid && sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if ({inst_pc, inst_data} !== {e.pc, e.data}) begin
                    n_bad++;
                    $display("FAIL t3_pre got %h/%h want %h/%h",
                             inst_pc, inst_data, e.pc, e.data);
                end
                if (e.pc == 32'h1C) seen = 1'b1;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL t3_reach got no pc 1c want pc 1c");
        end
        branch_valid  = 1'b1;
        branch_target = 32'h4;
        #1;
        n_cmp++;
        if (req_valid !== 1'b0) begin
            n_bad++; $display("FAIL t3_branch_req got %b want 0", req_valid);
        end
        @(negedge clk);
        branch_valid = 1'b0;
        sb.delete();
        push_stream(32'h4, 3);
        #1;
        n_cmp++;
        if (inst_valid !== 1'b0) begin
            n_bad++; $display("FAIL t3_flush got %b want 0", inst_valid);
        end
        popped = 0;
        repeat (30) begin
            @(negedge clk);
            #1;
            if (inst_valid && popped < 3) begin
                e = sb.pop_front();
                n_cmp++;
                if ({inst_pc, inst_data} !== {e.pc, e.data}) begin
                    n_bad++;
                    $display("FAIL t3_pop got %h/%h want %h/%h",
                             inst_pc, inst_data, e.pc, e.data);
                end
                popped++;
            end
        end
        n_cmp++;
        if (popped !== 3 || proto_err !== 1'b0) begin
            n_bad++;
            $display("FAIL t3_end got pops=%0d perr=%b want 3/0",
                     popped, proto_err);
        end
    endtask

    task automatic test_out_of_range;
        int          n_req;
        int          popped;
        logic [31:0] bad_addr;
        exp_t        e;
        start_run(1, 1'b1);
        @(negedge clk);
        branch_valid  = 1'b1;
        branch_target = 32'hFC;
        @(negedge clk);
        branch_valid = 1'b0;
        sb.delete();
        push_stream(32'hFC, 3);
        n_req    = 0;
        popped   = 0;
        bad_addr = 32'hFC;
        repeat (20) begin
            #1;
            if (req_valid) begin
                n_req++;
                if (req_addr != 32'hFC) bad_addr = req_addr;
            end
            if (inst_valid && popped < 3) begin
                e = sb.pop_front();
                n_cmp++;
                if ({inst_pc, inst_data} !== {e.pc, e.data}) begin
                    n_bad++;
                    $display("FAIL t4_pop got %h/%h want %h/%h",
                             inst_pc, inst_data, e.pc, e.data);
                end
                popped++;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (n_req !== 1 || bad_addr !== 32'hFC) begin
            n_bad++;
            $display("FAIL t4_reqs got n=%0d addr=%h want 1/000000fc",
                     n_req, bad_addr);
        end
        n_cmp++;
        if (popped !== 3) begin
            n_bad++; $display("FAIL t4_count got %0d want 3", popped);
        end
    endtask

    task automatic test_branch_with_resp;
        int   popped;
        logic hit;
        exp_t e;
        start_run(1, 1'b1);
        hit = 1'b0;
        for (int k = 0; k < 10 && !hit; k++) begin
            #1;
            if (resp_valid) begin
                hit           = 1'b1;
                branch_valid  = 1'b1;
                branch_target = 32'h0A;
            end
            @(negedge clk);
        end
        branch_valid = 1'b0;
        sb.delete();
        push_stream(32'h8, 3);
        #1;
        n_cmp++;
        if (!hit || {req_valid, req_addr} !== {1'b1, 32'h8}) begin
            n_bad++;
            $display("FAIL t5_first_req got hit=%b %b/%h want 1 1/00000008",
                     hit, req_valid, req_addr);
        end
        popped = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (inst_valid && popped < 3) begin
                e = sb.pop_front();
                n_cmp++;
                if ({inst_pc, inst_data} !== {e.pc, e.data}) begin
                    n_bad++;
                    $display("FAIL t5_pop got %h/%h want %h/%h",
                             inst_pc, inst_data, e.pc, e.data);
                end
                popped++;
            end
        end
        n_cmp++;
        if (popped !== 3 || proto_err !== 1'b0) begin
            n_bad++;
            $display("FAIL t5_end got pops=%0d perr=%b want 3/0",
                     popped, proto_err);
        end
    endtask

    task automatic test_proto_and_reset;
        int   popped;
        exp_t e;
        start_run(1, 1'b0);
        push_stream(32'h0, 4);
        repeat (10) @(negedge clk);
        #1;
        n_cmp++;
        if (proto_err !== 1'b0) begin
            n_bad++; $display("FAIL t6_pre got %b want 0", proto_err);
        end
        @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (proto_err !== 1'b1) begin
            n_bad++; $display("FAIL t6_set got %b want 1", proto_err);
        end
        repeat (5) @(negedge clk);
        #1;
        n_cmp++;
        if (proto_err !== 1'b1) begin
            n_bad++; $display("FAIL t6_sticky got %b want 1", proto_err);
        end
        @(negedge clk);
        lat        = 3;
        inst_ready = 1'b1;
        popped     = 0;
        repeat (10) begin
            #1;
            if (inst_valid && popped < 4) begin
                e = sb.pop_front();
                n_cmp++;
                if ({inst_pc, inst_data} !== {e.pc, e.data}) begin
                    n_bad++;
                    $display("FAIL t6_pop got %h/%h want %h/%h",
                             inst_pc, inst_data, e.pc, e.data);
                end
                popped++;
            end
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({req_valid, req_addr, inst_valid, inst_data, inst_pc, proto_err}
            !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL t6_reset got rv=%b ra=%h iv=%b id=%h ip=%h pe=%b want all 0",
                     req_valid, req_addr, inst_valid, inst_data,
                     inst_pc, proto_err);
        end
        sb.delete();
        push_stream(32'h0, 2);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) begin
            #1;
            if (inst_valid && popped < 6) begin
                e = sb.pop_front();
                n_cmp++;
                if ({inst_pc, inst_data} !== {e.pc, e.data}) begin
                    n_bad++;
                    $display("FAIL t6_restart got %h/%h want %h/%h",
                             inst_pc, inst_data, e.pc, e.data);
                end
                popped++;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (popped !== 6) begin
            n_bad++; $display("FAIL t6_count got %0d want 6", popped);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i * 4);
        mem[0] = 32'h0250_8826;
        mem[1] = 32'h0232_4020;
        mem[2] = 32'h0250_8822;
        mem[7] = 32'h1240_fffc;
        reset         = 1'b1;
        req_ready     = 1'b1;
        inst_ready    = 1'b1;
        branch_valid  = 1'b0;
        branch_target = 32'h0;
        test_reset_stream();
        test_backpressure();
        test_branch_inflight();
        test_out_of_range();
        test_branch_with_resp();
        test_proto_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
